// File: rtl/decodmorse_key.sv
// rtl/decodmorse_key.sv - Morse key decoder: debounced key timing to 6-bit symbol code
module decodmorse_key #(
    parameter int UNIT    = 50000,
    parameter int DEB     = 1000,
    parameter int DASH_U  = 2,
    parameter int GAP_U   = 3,
    parameter int STUCK_U = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key,
    output logic [5:0] num,
    output logic [4:0] morse,
    output logic [4:0] display,
    output logic       ready,
    output logic       error,
    output logic       busy
);
    localparam int STUCK_N = STUCK_U * UNIT;
    localparam int CW      = $clog2(STUCK_N + 1);
    localparam int DW      = $clog2(DEB + 1);
    localparam logic [CW-1:0] DASH_LIM  = CW'(DASH_U * UNIT);
    localparam logic [CW-1:0] GAP_LIM   = CW'(GAP_U * UNIT);
    localparam logic [CW-1:0] STUCK_LIM = CW'(STUCK_N);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB - 1);

    typedef enum logic [2:0] {IDLE, PRESS, GAP, EMIT, ERR} state_t;

    state_t        state;
    logic          s1, s2, kd, kd_q;
    logic [DW-1:0] deb_cnt;
    logic [CW-1:0] cnt;
    logic [2:0]    sym_cnt;
    logic [4:0]    morse_sr, disp_sr;
    logic          dec_ok;
    logic [5:0]    dec_num;
    logic          rise, fall;

    assign rise = kd & ~kd_q;
    assign fall = ~kd & kd_q;

    // Encoder table {display, morse} for code n; the decoder searches it.
    function automatic logic [9:0] enc(input logic [5:0] n);
        logic [7:0] lp;
        logic [4:0] d, m;
        lp = 8'd0;
        case (n)
            6'd0:  lp = {3'd5, 5'b00000};
            6'd1:  lp = {3'd5, 5'b10000};
            6'd2:  lp = {3'd5, 5'b11000};
            6'd3:  lp = {3'd5, 5'b11100};
            6'd4:  lp = {3'd5, 5'b11110};
            6'd5:  lp = {3'd5, 5'b11111};
            6'd6:  lp = {3'd5, 5'b01111};
            6'd7:  lp = {3'd5, 5'b00111};
            6'd8:  lp = {3'd5, 5'b00011};
            6'd9:  lp = {3'd5, 5'b00001};
            6'd10: lp = {3'd2, 5'b00010};
            6'd11: lp = {3'd4, 5'b00111};
            6'd12: lp = {3'd4, 5'b00101};
            6'd13: lp = {3'd3, 5'b00011};
            6'd14: lp = {3'd1, 5'b00001};
            6'd15: lp = {3'd4, 5'b01101};
            6'd16: lp = {3'd3, 5'b00001};
            6'd17: lp = {3'd4, 5'b01111};
            6'd18: lp = {3'd2, 5'b00011};
            6'd19: lp = {3'd4, 5'b01000};
            6'd20: lp = {3'd3, 5'b00010};
            6'd21: lp = {3'd4, 5'b01011};
            6'd22: lp = {3'd2, 5'b00000};
            6'd23: lp = {3'd2, 5'b00001};
            6'd24: lp = {3'd3, 5'b00000};
            6'd25: lp = {3'd4, 5'b01001};
            6'd26: lp = {3'd4, 5'b00010};
            6'd27: lp = {3'd3, 5'b00101};
            6'd28: lp = {3'd3, 5'b00111};
            6'd29: lp = {3'd1, 5'b00000};
            6'd30: lp = {3'd3, 5'b00110};
            6'd31: lp = {3'd4, 5'b01110};
            6'd32: lp = {3'd3, 5'b00100};
            6'd33: lp = {3'd4, 5'b00110};
            6'd34: lp = {3'd4, 5'b00100};
            6'd35: lp = {3'd4, 5'b00011};
            default: lp = 8'd0;
        endcase
        d = 5'b11111 << (3'd5 - lp[7:5]);
        m = lp[4:0] << (3'd5 - lp[7:5]);
        return {d, m};
    endfunction

    always_comb begin
        dec_ok  = 1'b0;
        dec_num = 6'd0;
        for (int i = 0; i < 36; i++) begin
            if (enc(6'(i)) == {disp_sr, morse_sr}) begin
                dec_ok  = 1'b1;
                dec_num = 6'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            kd      <= 1'b0;
            kd_q    <= 1'b0;
            deb_cnt <= '0;
            cnt     <= '0;
        end else begin
            s1   <= key;
            s2   <= s1;
            kd_q <= kd;
            if (s2 == kd) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                kd      <= s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
            if (kd != kd_q)
                cnt <= '0;
            else if (cnt != STUCK_LIM)
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            num      <= 6'd0;
            morse    <= 5'd0;
            display  <= 5'd0;
            ready    <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b0;
            sym_cnt  <= 3'd0;
            morse_sr <= 5'd0;
            disp_sr  <= 5'd0;
        end else begin
            ready <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: if (kd) begin
                    state    <= PRESS;
                    busy     <= 1'b1;
                    sym_cnt  <= 3'd0;
                    morse_sr <= 5'd0;
                    disp_sr  <= 5'd0;
                end
                PRESS: if (fall) begin
                    if (sym_cnt == 3'd5) begin
                        state <= ERR;
                        error <= 1'b1;
                    end else begin
                        morse_sr[3'd4 - sym_cnt] <= (cnt < DASH_LIM);
                        disp_sr[3'd4 - sym_cnt]  <= 1'b1;
                        sym_cnt <= sym_cnt + 3'd1;
                        state   <= GAP;
                    end
                end else if (cnt == STUCK_LIM) begin
                    state <= ERR;
                    error <= 1'b1;
                end
                // End of character takes priority over a simultaneous new press.
                GAP: if (cnt >= GAP_LIM)
                    state <= EMIT;
                else if (rise)
                    state <= PRESS;
                EMIT: begin
                    if (dec_ok) begin
                        num     <= dec_num;
                        morse   <= morse_sr;
                        display <= disp_sr;
                        ready   <= 1'b1;
                    end else begin
                        error <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ERR: if (!kd) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
